// File: rtl/bldc_pkg.sv
// Shared types and helpers for the six-step Hall commutator:
// hall codes, forward sequence neighbours, commutation table.
package bldc_pkg;

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        DRV_Z   = 2'd0,
        DRV_LOW = 2'd1,
        DRV_RUN = 2'd2
    } drv_mode_e;

    typedef struct packed {
        phase_e pwm_sel;
        phase_e low_sel;
    } comm_t;

    localparam logic [2:0] HALL_NONE = 3'b000;
    localparam logic [2:0] HALL_1    = 3'b001;
    localparam logic [2:0] HALL_2    = 3'b011;
    localparam logic [2:0] HALL_3    = 3'b010;
    localparam logic [2:0] HALL_4    = 3'b110;
    localparam logic [2:0] HALL_5    = 3'b100;
    localparam logic [2:0] HALL_6    = 3'b101;
    localparam logic [2:0] HALL_ALL  = 3'b111;

    function automatic logic hall_legal(input logic [2:0] c);
        return (c != HALL_NONE) && (c != HALL_ALL);
    endfunction

    function automatic logic [2:0] fwd_next(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            HALL_1:  n = HALL_2;
            HALL_2:  n = HALL_3;
            HALL_3:  n = HALL_4;
            HALL_4:  n = HALL_5;
            HALL_5:  n = HALL_6;
            HALL_6:  n = HALL_1;
            default: n = HALL_NONE;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] fwd_prev(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            HALL_1:  n = HALL_6;
            HALL_2:  n = HALL_1;
            HALL_3:  n = HALL_2;
            HALL_4:  n = HALL_3;
            HALL_5:  n = HALL_4;
            HALL_6:  n = HALL_5;
            default: n = HALL_NONE;
        endcase
        return n;
    endfunction

    // Reverse drive swaps the PWM and low phases; Z phase is unchanged.
    function automatic comm_t comm_table(input logic [2:0] c,
                                         input logic       dir);
        comm_t t;
        case (c)
            HALL_1:  t = '{pwm_sel: PH_A, low_sel: PH_B};
            HALL_2:  t = '{pwm_sel: PH_A, low_sel: PH_C};
            HALL_3:  t = '{pwm_sel: PH_B, low_sel: PH_C};
            HALL_4:  t = '{pwm_sel: PH_B, low_sel: PH_A};
            HALL_5:  t = '{pwm_sel: PH_C, low_sel: PH_A};
            HALL_6:  t = '{pwm_sel: PH_C, low_sel: PH_B};
            default: t = '{pwm_sel: PH_A, low_sel: PH_B};
        endcase
        if (dir) begin
            t = '{pwm_sel: t.low_sel, low_sel: t.pwm_sel};
        end
        return t;
    endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input path: 2-FF synchroniser then a depth filter.
// Ports: clk, rst, hall in; code, code_valid, changed (1-cycle) out.
module hall_filter
    import bldc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       changed
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [2:0]    s1, s2, cand, cand_nxt;
    logic [1:0]    fill;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          primed, accept;

    // fill marks when s2 holds a real sample rather than reset contents.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        accept   = 1'b0;
        if (fill[1]) begin
            if (cnt == '0 || s2 != cand) begin
                cand_nxt = s2;
                cnt_nxt  = ONE;
            end else if (cnt != FULL) begin
                cnt_nxt = cnt + ONE;
            end
            accept = (cnt_nxt == FULL) &&
                     (!primed || cand_nxt != code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            fill       <= '0;
            cand       <= '0;
            cnt        <= '0;
            code       <= '0;
            primed     <= 1'b0;
            code_valid <= 1'b0;
            changed    <= 1'b0;
        end else begin
            s1      <= hall;
            s2      <= s1;
            fill    <= {fill[0], 1'b1};
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            changed <= accept;
            if (accept) begin
                code   <= cand_nxt;
                primed <= 1'b1;
                if (hall_legal(cand_nxt)) begin
                    code_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step Hall commutator feeding three phase drivers.
// Ports: clk, rst, en, direction, brake, duty_cycle_in, hall in;
//   duty_a/b/c, high_z_a/b/c, hall_count, hall_fault, stall out.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DUTY_CYCLE_WIDTH  = 10,
    parameter int MAX_DUTY_CYCLE    = 1023,
    parameter int HALL_FILTER_DEPTH = 4,
    parameter int STALL_TIMEOUT     = 500000,
    parameter int STALL_CNT_WIDTH   = 20,
    parameter int HALL_COUNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        direction,
    input  logic                        brake,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle_in,
    input  logic [2:0]                  hall,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic [HALL_COUNT_WIDTH-1:0] hall_count,
    output logic                        hall_fault,
    output logic                        stall
);

    localparam int DCW = DUTY_CYCLE_WIDTH;
    localparam int DW1 = DCW + 1;
    localparam int SCW = STALL_CNT_WIDTH;
    localparam int HCW = HALL_COUNT_WIDTH;

    localparam logic [DW1-1:0] MAX_D     = DW1'(MAX_DUTY_CYCLE);
    localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_TIMEOUT);

    logic [2:0]              f_code;
    logic                    f_valid, f_chg;
    logic [2:0]              last_code;
    logic [SCW-1:0]          stall_cnt;
    logic                    legal, no_ref;
    logic                    step_fwd, step_rev, jump, bad;
    logic                    fault_nxt, stall_nxt, cnt_clr;
    logic [DCW-1:0]          duty_cl;
    comm_t                   tbl;
    drv_mode_e               mode;
    logic [2:0][DCW-1:0]     duty_n;
    logic [2:0]              hz_n;

    hall_filter #(
        .DEPTH      (HALL_FILTER_DEPTH)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .hall       (hall),
        .code       (f_code),
        .code_valid (f_valid),
        .changed    (f_chg)
    );

    // last_code holds the last accepted legal code; 000 means none yet.
    assign legal    = hall_legal(f_code);
    assign no_ref   = (last_code == HALL_NONE);
    assign step_fwd = f_chg && legal && !no_ref &&
                      (f_code == fwd_next(last_code));
    assign step_rev = f_chg && legal && !no_ref &&
                      (f_code == fwd_prev(last_code));
    assign jump     = f_chg && legal && !no_ref &&
                      (f_code != last_code) &&
                      !step_fwd && !step_rev;
    assign bad      = f_chg && !legal;

    // en low clears the sticky flags and beats any same-cycle set.
    assign fault_nxt = en && (hall_fault || bad || jump);
    assign stall_nxt = en && (stall || (stall_cnt == STALL_LIM));
    assign cnt_clr   = f_chg || !en || brake ||
                       (duty_cycle_in == '0);

    assign duty_cl = ({1'b0, duty_cycle_in} > MAX_D) ?
                     MAX_D[DCW-1:0] : duty_cycle_in;
    assign tbl     = comm_table(f_code, direction);

    always_comb begin
        mode = DRV_RUN;
        if (!en || !f_valid || !legal) begin
            mode = DRV_Z;
        end else if (fault_nxt || stall_nxt) begin
            mode = DRV_Z;
        end else if (brake) begin
            mode = DRV_LOW;
        end
    end

    always_comb begin
        duty_n = '0;
        hz_n   = '1;
        for (int p = 0; p < 3; p++) begin
            unique case (mode)
                DRV_LOW: hz_n[p] = 1'b0;
                DRV_RUN: begin
                    if (tbl.pwm_sel == phase_e'(p)) begin
                        duty_n[p] = duty_cl;
                        hz_n[p]   = 1'b0;
                    end else if (tbl.low_sel == phase_e'(p)) begin
                        hz_n[p] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_a     <= '0;
            duty_b     <= '0;
            duty_c     <= '0;
            high_z_a   <= 1'b1;
            high_z_b   <= 1'b1;
            high_z_c   <= 1'b1;
            hall_count <= '0;
            hall_fault <= 1'b0;
            stall      <= 1'b0;
            last_code  <= HALL_NONE;
            stall_cnt  <= '0;
        end else begin
            duty_a     <= duty_n[0];
            duty_b     <= duty_n[1];
            duty_c     <= duty_n[2];
            high_z_a   <= hz_n[0];
            high_z_b   <= hz_n[1];
            high_z_c   <= hz_n[2];
            hall_fault <= fault_nxt;
            stall      <= stall_nxt;
            if (f_chg && legal) begin
                last_code <= f_code;
            end
            if (step_fwd) begin
                hall_count <= hall_count + HCW'(1);
            end else if (step_rev) begin
                hall_count <= hall_count - HCW'(1);
            end
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + SCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// Testbench for bldc_commutator: directed scenarios plus a random
// walk, all checked cycle-by-cycle against a sliding-window model.
module tb_bldc_commutator;

    localparam int DCW  = 10;
    localparam int MAXD = 1000;
    localparam int DEP  = 4;
    localparam int TMO  = 200;
    localparam int SCW  = 20;
    localparam int HCW  = 16;

    logic           clk = 1'b0;
    logic           rst, en, direction, brake;
    logic [DCW-1:0] duty_in;
    logic [2:0]     hall;
    logic [DCW-1:0] duty_a, duty_b, duty_c;
    logic           high_z_a, high_z_b, high_z_c;
    logic [HCW-1:0] hall_count;
    logic           hall_fault, stall;

    always #5 clk = ~clk;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH  (DCW),
        .MAX_DUTY_CYCLE    (MAXD),
        .HALL_FILTER_DEPTH (DEP),
        .STALL_TIMEOUT     (TMO),
        .STALL_CNT_WIDTH   (SCW),
        .HALL_COUNT_WIDTH  (HCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .direction     (direction),
        .brake         (brake),
        .duty_cycle_in (duty_in),
        .hall          (hall),
        .duty_a        (duty_a),
        .duty_b        (duty_b),
        .duty_c        (duty_c),
        .high_z_a      (high_z_a),
        .high_z_b      (high_z_b),
        .high_z_c      (high_z_c),
        .hall_count    (hall_count),
        .hall_fault    (hall_fault),
        .stall         (stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Forward sequence and its drive table (phase 0=A,1=B,2=C).
    bit [2:0] SEQ   [6] = '{3'b001, 3'b011, 3'b010,
                            3'b110, 3'b100, 3'b101};
    int       PWM_F [6] = '{0, 0, 1, 1, 2, 2};
    int       LOW_F [6] = '{1, 2, 2, 0, 0, 1};

    function automatic int seq_idx(input bit [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (SEQ[i] == c) return i;
        end
        return -1;
    endfunction

    // Model state.
    bit [2:0] raw [$];
    bit [2:0] m_fc, m_last;
    bit       m_primed, m_fvalid, m_chg;
    bit       m_fault, m_stall, m_live = 1'b0;
    int       m_cnt, m_scnt;
    int       e_duty [3];
    bit [2:0] e_hz;

    // Advance the model across one rising edge using current inputs.
    task automatic model_step();
        int       ci, li, pw, lo, n;
        bit       hit, same;
        bit [2:0] v;
        if (rst) begin
            raw.delete();
            m_fc = 0; m_last = 0; m_primed = 0; m_fvalid = 0;
            m_chg = 0; m_fault = 0; m_stall = 0;
            m_cnt = 0; m_scnt = 0;
            e_duty = '{0, 0, 0};
            e_hz = 3'b111;
            m_live = 1'b1;
            return;
        end
        // Control layer acts on what the filter accepted last edge.
        hit = (m_scnt == TMO);
        if (m_chg) begin
            ci = seq_idx(m_fc);
            li = seq_idx(m_last);
            if (ci < 0) begin
                m_fault = 1;
            end else begin
                if (li >= 0) begin
                    if (ci == (li + 1) % 6)      m_cnt++;
                    else if (ci == (li + 5) % 6) m_cnt--;
                    else if (ci != li)           m_fault = 1;
                end
                m_last = m_fc;
            end
        end
        if (hit) m_stall = 1;
        if (!en) begin
            m_fault = 0;
            m_stall = 0;
        end
        if (m_chg || !en || brake || duty_in == 0) m_scnt = 0;
        else if (m_scnt < (1 << SCW) - 1)        m_scnt++;
        e_duty = '{0, 0, 0};
        e_hz   = 3'b111;
        ci     = seq_idx(m_fc);
        if (en && m_fvalid && ci >= 0 && !m_fault && !m_stall) begin
            if (brake) begin
                e_hz = 3'b000;
            end else begin
                pw = direction ? LOW_F[ci] : PWM_F[ci];
                lo = direction ? PWM_F[ci] : LOW_F[ci];
                e_duty[pw] = (int'(duty_in) > MAXD) ? MAXD : int'(duty_in);
                e_hz[pw] = 1'b0;
                e_hz[lo] = 1'b0;
            end
        end
        // Filter layer: accept once the last DEP synced samples agree.
        raw.push_back(hall);
        if (raw.size() > DEP + 2) void'(raw.pop_front());
        m_chg = 0;
        n = raw.size();
        if (n - 2 >= DEP) begin
            v    = raw[n - 3];
            same = 1;
            for (int k = 0; k < DEP; k++) begin
                if (raw[n - 3 - k] != v) same = 0;
            end
            if (same && (!m_primed || v != m_fc)) begin
                m_fc     = v;
                m_primed = 1;
                m_chg    = 1;
                if (seq_idx(v) >= 0) m_fvalid = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] ec;
        ec = m_cnt[15:0];
        check("duty_a", 32'(duty_a), e_duty[0]);
        check("duty_b", 32'(duty_b), e_duty[1]);
        check("duty_c", 32'(duty_c), e_duty[2]);
        check("high_z", 32'({high_z_c, high_z_b, high_z_a}), 32'(e_hz));
        check("hall_count", 32'(hall_count), 32'(ec));
        check("hall_fault", 32'(hall_fault), 32'(m_fault));
        check("stall", 32'(stall), 32'(m_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_live) compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] hz3();
        return 32'({high_z_c, high_z_b, high_z_a});
    endfunction

    int idx;
    int r;

    initial begin
        rst = 1; en = 0; direction = 0; brake = 0;
        duty_in = '0; hall = 3'b001;
        ticks(2);
        check("rst_hz", hz3(), 32'h7);
        check("rst_cnt", 32'(hall_count), 0);

        // Hold 001: drive appears exactly 2+DEP+1 edges later.
        rst = 0; en = 1; duty_in = 10'd512;
        ticks(6);
        check("lat_early_hz", hz3(), 32'h7);
        tick();
        check("t1_duty_a", 32'(duty_a), 512);
        check("t1_hz", hz3(), 32'b100);
        check("t1_duty_b", 32'(duty_b), 0);

        // Full forward turn then reverse turn.
        for (int i = 1; i <= 6; i++) begin
            hall = SEQ[i % 6];
            ticks(8);
        end
        check("fwd_count", 32'(hall_count), 6);
        direction = 1;
        for (int i = 5; i >= 0; i--) begin
            hall = SEQ[i];
            ticks(8);
        end
        check("rev_count", 32'(hall_count), 0);
        check("rev_duty_b", 32'(duty_b), 512);
        check("rev_hz", hz3(), 32'b100);
        direction = 0;
        ticks(1);

        // Short glitch is filtered out.
        hall = 3'b011;
        ticks(2);
        hall = 3'b001;
        ticks(10);
        check("glitch_count", 32'(hall_count), 0);
        check("glitch_duty_a", 32'(duty_a), 512);

        // Illegal code faults; en low clears; drive resumes.
        hall = 3'b111;
        ticks(8);
        check("f_fault", 32'(hall_fault), 1);
        check("f_hz", hz3(), 32'h7);
        en = 0;
        tick();
        check("f_clear", 32'(hall_fault), 0);
        en = 1; hall = 3'b001;
        ticks(8);
        check("f_resume_hz", hz3(), 32'b100);
        check("f_resume_duty", 32'(duty_a), 512);

        // Stall timeout, then braking holds the counter clear.
        duty_in = 10'd100;
        ticks(TMO + 20);
        check("stall_set", 32'(stall), 1);
        check("stall_hz", hz3(), 32'h7);
        en = 0;
        tick();
        en = 1; brake = 1;
        ticks(TMO + 20);
        check("brake_stall", 32'(stall), 0);
        check("brake_hz", hz3(), 32'h0);
        check("brake_duty", 32'(duty_a), 0);

        // Clamp, then reset mid-rotation.
        brake = 0; duty_in = 10'd1023;
        ticks(3);
        check("clamp_duty", 32'(duty_a), MAXD);
        hall = 3'b011;
        ticks(8);
        check("pre_rst_cnt", 32'(hall_count), 1);
        rst = 1;
        tick();
        check("mid_rst_hz", hz3(), 32'h7);
        check("mid_rst_duty", 32'(duty_a), 0);
        check("mid_rst_cnt", 32'(hall_count), 0);
        rst = 0;

        // Random walk.
        idx = 1;
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                idx = ($urandom_range(0, 1) != 0) ? (idx + 1) % 6
                                                  : (idx + 5) % 6;
                hall = SEQ[idx];
            end else if (r < 78) begin
                hall = 3'($urandom_range(0, 7));
            end else if (r < 85) begin
                idx = $urandom_range(0, 5);
                hall = SEQ[idx];
            end
            if ($urandom_range(0, 7) == 0) direction = ~direction;
            brake = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 9) != 0);
            duty_in = ($urandom_range(0, 9) == 0) ? '0
                                                  : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 80) == 0) begin
                rst = 1;
                tick();
                rst = 0;
            end
            ticks($urandom_range(1, 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
